// File: rtl/regfile_dump_ctrl_if.sv
// rtl/regfile_dump_ctrl_if.sv - register read port and dump stream bundle for regfile_dump_ctrl
interface regfile_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] sel_r_a;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W-1:0] dout_idx;
  logic              dout_valid;
  logic              dout_ready;

  // Sequencer side: drives the read index and the output stream
  modport master (
    output sel_r_a,
    input  ra,
    output dout_data,
    output dout_idx,
    output dout_valid,
    input  dout_ready
  );

  // Register file and stream consumer side
  modport slave (
    input  sel_r_a,
    output ra,
    input  dout_data,
    input  dout_idx,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - debug sweep of register file read port A onto a valid/ready stream
module regfile_dump_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  regfile_dump_ctrl_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  state_t            state_q;
  logic [ADDR_W-1:0] sel_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] idx_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] csum_q;

  // Sweep sequencer; abort outranks every other input, and all outputs are registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q   <= FIRST_IDX;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csum_q  <= '0;
    end else if (abort_i) begin
      // Partial checksum is kept so a debugger can still inspect it
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sel_q   <= FIRST_IDX;
            csum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          // sel_q has been on the read port for a full cycle, so ra is settled
          data_q  <= bus.ra;
          idx_q   <= sel_q;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (valid_q && bus.dout_ready) begin
            csum_q  <= csum_q + data_q;
            valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              sel_q   <= sel_q + ADDR_W'(1);
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sel_r_a    = sel_q;
  assign bus.dout_data  = data_q;
  assign bus.dout_idx   = idx_q;
  assign bus.dout_valid = valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign checksum_o     = csum_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - directed self-checking bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [DW-1:0] rf [32];

  regfile_dump_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  assign bus.ra = rf[bus.sel_r_a];

  regfile_dump_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .abort_i(abort),
    .bus(bus),
    .busy_o(busy),
    .done_o(done),
    .checksum_o(checksum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] cap_data [64];
  logic [AW-1:0] cap_idx [64];
  int nw, nd, first_valid;
  bit stable_ok, timeout;

  // Run one sweep; mode 0 = ready tied high, mode 1 = ready toggling. restart_idx pulses start mid-sweep.
  task automatic do_sweep(input int mode, input int restart_idx);
    bit held, seen_done;
    logic [DW-1:0] hd;
    logic [AW-1:0] hi;
    nw = 0; nd = 0; first_valid = -1; stable_ok = 1; timeout = 1;
    held = 0; seen_done = 0; hd = '0; hi = '0;
    @(negedge clk);
    start = 1'b1;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (held && (!bus.dout_valid || bus.dout_data !== hd || bus.dout_idx !== hi)) stable_ok = 0;
      start = 1'b0;
      bus.dout_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (bus.dout_valid && first_valid < 0) first_valid = cyc;
      if (bus.dout_valid && int'(bus.dout_idx) == restart_idx) start = 1'b1;
      held = bus.dout_valid && !bus.dout_ready;
      hd = bus.dout_data;
      hi = bus.dout_idx;
      if (bus.dout_valid && bus.dout_ready && nw < 64) begin
        cap_data[nw] = bus.dout_data;
        cap_idx[nw] = bus.dout_idx;
        nw++;
      end
      if (done) begin
        nd++;
        seen_done = 1;
      end else if (seen_done && !busy) begin
        timeout = 0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.dout_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.sel_r_a !== 5'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.sel_r_a); end
    checks++; if (bus.dout_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.dout_data); end
    checks++; if (bus.dout_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus.dout_idx); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_after_reset();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sel_r_a !== 5'd0 || bus.dout_data !== 32'd0 || bus.dout_idx !== 5'd0 ||
          bus.dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || checksum !== 32'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_hold bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_ramp_sweep();
    int bad = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
    do_sweep(0, -1);
    for (int i = 0; i < 32 && i < nw; i++)
      if (cap_idx[i] !== 5'(i) || cap_data[i] !== 32'(3 * i)) bad++;
    checks++; if (timeout) begin errors++; $display("FAIL ramp_timeout got=1 exp=0"); end
    checks++; if (nw != 32) begin errors++; $display("FAIL ramp_count got=%0d exp=32", nw); end
    checks++; if (bad != 0) begin errors++; $display("FAIL ramp_words bad=%0d exp=0", bad); end
    checks++; if (nd != 1) begin errors++; $display("FAIL ramp_done_pulses got=%0d exp=1", nd); end
    checks++; if (checksum !== 32'd1488) begin errors++; $display("FAIL ramp_checksum got=%0d exp=1488", checksum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy got=%b exp=0", busy); end
    checks++; if (first_valid != 1) begin errors++; $display("FAIL ramp_first_valid got=%0d exp=1", first_valid); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd55;
    do_sweep(1, -1);
    for (int i = 0; i < 32 && i < nw; i++)
      if (cap_idx[i] !== 5'(i) || cap_data[i] !== 32'd55) bad++;
    checks++; if (nw != 32) begin errors++; $display("FAIL bp_count got=%0d exp=32", nw); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_words bad=%0d exp=0", bad); end
    checks++; if (!stable_ok) begin errors++; $display("FAIL bp_stable got=0 exp=1"); end
    checks++; if (nd != 1) begin errors++; $display("FAIL bp_done_pulses got=%0d exp=1", nd); end
    checks++; if (checksum !== 32'd1760) begin errors++; $display("FAIL bp_checksum got=%0d exp=1760", checksum); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
    do_sweep(0, -1);
    checks++; if (nw != 32) begin errors++; $display("FAIL wrap_count got=%0d exp=32", nw); end
    checks++; if (checksum !== 32'hFFFF_FFE0) begin errors++; $display("FAIL wrap_checksum got=%h exp=ffffffe0", checksum); end
  endtask

  task automatic test_abort();
    bit found = 0;
    int ndone = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
    @(negedge clk);
    start = 1'b1;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) ndone++;
      if (bus.dout_valid && bus.dout_idx == 5'd5) begin
        bus.dout_ready = 1'b0;
        abort = 1'b1;
        found = 1;
        break;
      end
      bus.dout_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    abort = 1'b0;
    if (done) ndone++;
    checks++; if (!found) begin errors++; $display("FAIL abort_reach_idx5 got=0 exp=1"); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", bus.dout_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", ndone); end
    checks++; if (checksum !== 32'd30) begin errors++; $display("FAIL abort_checksum got=%0d exp=30", checksum); end
    do_sweep(0, -1);
    checks++; if (nw != 32 || cap_idx[0] !== 5'd0) begin errors++; $display("FAIL abort_restart count=%0d first_idx=%0d exp=32/0", nw, cap_idx[0]); end
    checks++; if (checksum !== 32'd1488) begin errors++; $display("FAIL abort_restart_checksum got=%0d exp=1488", checksum); end
  endtask

  task automatic test_start_ignored();
    int bad = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
    do_sweep(0, 7);
    for (int i = 0; i < 32 && i < nw; i++)
      if (cap_idx[i] !== 5'(i) || cap_data[i] !== 32'(3 * i)) bad++;
    checks++; if (nw != 32 || bad != 0) begin errors++; $display("FAIL restart_ignored count=%0d bad=%0d exp=32/0", nw, bad); end
    checks++; if (nd != 1 || checksum !== 32'd1488) begin errors++; $display("FAIL restart_done_sum done=%0d sum=%0d exp=1/1488", nd, checksum); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_no_queue busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 0;
    @(negedge clk);
    start = 1'b1;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bus.dout_valid && bus.dout_idx == 5'd10) begin
        rst_n = 1'b0;
        found = 1;
        break;
      end
      @(negedge clk);
    end
    #1;
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach_idx10 got=0 exp=1"); end
    checks++; if (bus.dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl valid=%b busy=%b done=%b exp=0/0/0", bus.dout_valid, busy, done); end
    checks++; if (bus.sel_r_a !== 5'd0 || bus.dout_idx !== 5'd0 || bus.dout_data !== 32'd0 || checksum !== 32'd0) begin errors++; $display("FAIL rst_mid_data sel=%0d idx=%0d data=%h sum=%h exp=0", bus.sel_r_a, bus.dout_idx, bus.dout_data, checksum); end
    bus.dout_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stays_idle busy=%b valid=%b exp=0/0", busy, bus.dout_valid); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    bus.dout_ready = 1'b0;
    test_reset();
    test_idle_after_reset();
    test_ramp_sweep();
    test_backpressure();
    test_wrap();
    test_abort();
    test_start_ignored();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
